// File: rtl/comb_sched.sv
// Pair scheduler for the Fibonacci combiner: arbitrates two channels, feeds each word pair
// through the combiner and holds the captured result for the downstream consumer.
module comb_sched #(
   parameter int unsigned TIMEOUT = 1023
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0,
   input  logic        req1,
   input  logic [15:0] wa0,
   input  logic [15:0] wb0,
   input  logic [15:0] wa1,
   input  logic [15:0] wb1,
   output logic        gnt0,
   output logic        gnt1,
   output logic        cmb_rst_n,
   output logic        cmb_en,
   output logic [15:0] cmb_b,
   input  logic        cmb_done,
   input  logic        cmb_done_comb,
   input  logic [63:0] cmb_S,
   input  logic [63:0] cmb_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_S,
   output logic [63:0] out_data,
   output logic        out_ch,
   output logic        timeout_err
);

   localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT);

   typedef enum logic [2:0] {
      StIdle,
      StClr,
      StFeedA,
      StWaitA,
      StFeedB,
      StWaitB,
      StOut,
      StAbort
   } state_e;

   state_e         state_q;
   logic           gnt0_q, gnt1_q;
   logic           cmb_rst_n_q, cmb_en_q;
   logic [15:0]    cmb_b_q;
   logic [15:0]    wa_q, wb_q;
   logic           ch_q, last_ch_q;
   logic           out_valid_q, out_ch_q, timeout_err_q;
   logic [63:0]    out_s_q, out_data_q;
   logic [CntW-1:0] wait_cnt_q;

   logic grant_any, grant_ch;

   // On a tie the channel that was not served last wins.
   always_comb begin
      grant_any = req0 | req1;
      if (req0 && req1) begin
         grant_ch = ~last_ch_q;
      end else begin
         grant_ch = req1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= StIdle;
         gnt0_q        <= 1'b0;
         gnt1_q        <= 1'b0;
         cmb_rst_n_q   <= 1'b0;
         cmb_en_q      <= 1'b0;
         cmb_b_q       <= 16'h0000;
         wa_q          <= 16'h0000;
         wb_q          <= 16'h0000;
         ch_q          <= 1'b0;
         last_ch_q     <= 1'b1;
         out_valid_q   <= 1'b0;
         out_s_q       <= 64'h0;
         out_data_q    <= 64'h0;
         out_ch_q      <= 1'b0;
         timeout_err_q <= 1'b0;
         wait_cnt_q    <= '0;
      end else begin
         gnt0_q        <= 1'b0;
         gnt1_q        <= 1'b0;
         timeout_err_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               cmb_rst_n_q <= 1'b1;
               if (grant_any) begin
                  gnt0_q      <= ~grant_ch;
                  gnt1_q      <= grant_ch;
                  ch_q        <= grant_ch;
                  last_ch_q   <= grant_ch;
                  wa_q        <= grant_ch ? wa1 : wa0;
                  wb_q        <= grant_ch ? wb1 : wb0;
                  cmb_rst_n_q <= 1'b0;
                  state_q     <= StClr;
               end
            end
            StClr: begin
               cmb_rst_n_q <= 1'b1;
               cmb_en_q    <= 1'b1;
               cmb_b_q     <= wa_q;
               state_q     <= StFeedA;
            end
            StFeedA: begin
               cmb_en_q   <= 1'b0;
               wait_cnt_q <= '0;
               state_q    <= StWaitA;
            end
            StWaitA: begin
               // Completion wins over an abort landing on the same cycle.
               if (cmb_done) begin
                  cmb_en_q <= 1'b1;
                  cmb_b_q  <= wb_q;
                  state_q  <= StFeedB;
               end else if (wait_cnt_q == CntMax) begin
                  timeout_err_q <= 1'b1;
                  cmb_rst_n_q   <= 1'b0;
                  state_q       <= StAbort;
               end else begin
                  wait_cnt_q <= wait_cnt_q + CntW'(1);
               end
            end
            StFeedB: begin
               cmb_en_q   <= 1'b0;
               wait_cnt_q <= '0;
               state_q    <= StWaitB;
            end
            StWaitB: begin
               if (cmb_done_comb) begin
                  out_valid_q <= 1'b1;
                  out_s_q     <= cmb_S;
                  out_data_q  <= cmb_data;
                  out_ch_q    <= ch_q;
                  state_q     <= StOut;
               end else if (wait_cnt_q == CntMax) begin
                  timeout_err_q <= 1'b1;
                  cmb_rst_n_q   <= 1'b0;
                  state_q       <= StAbort;
               end else begin
                  wait_cnt_q <= wait_cnt_q + CntW'(1);
               end
            end
            StOut: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= StIdle;
               end
            end
            StAbort: begin
               cmb_rst_n_q <= 1'b1;
               state_q     <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign gnt0        = gnt0_q;
   assign gnt1        = gnt1_q;
   assign cmb_rst_n   = cmb_rst_n_q;
   assign cmb_en      = cmb_en_q;
   assign cmb_b       = cmb_b_q;
   assign out_valid   = out_valid_q;
   assign out_S       = out_s_q;
   assign out_data    = out_data_q;
   assign out_ch      = out_ch_q;
   assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_comb_sched.sv
// Directed bench for comb_sched with a behavioural combiner whose latency can be tuned.
module tb_comb_sched;

   localparam int unsigned Timeout = 15;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0, req1;
   logic [15:0] wa0, wb0, wa1, wb1;
   logic        gnt0, gnt1;
   logic        cmb_rst_n, cmb_en;
   logic [15:0] cmb_b;
   logic        cmb_done, cmb_done_comb;
   logic [63:0] cmb_S, cmb_data;
   logic        out_valid, out_ready;
   logic [63:0] out_S, out_data;
   logic        out_ch;
   logic        timeout_err;

   comb_sched #(.TIMEOUT(Timeout)) dut (
      .clk           (clk),
      .rst           (rst),
      .req0          (req0),
      .req1          (req1),
      .wa0           (wa0),
      .wb0           (wb0),
      .wa1           (wa1),
      .wb1           (wb1),
      .gnt0          (gnt0),
      .gnt1          (gnt1),
      .cmb_rst_n     (cmb_rst_n),
      .cmb_en        (cmb_en),
      .cmb_b         (cmb_b),
      .cmb_done      (cmb_done),
      .cmb_done_comb (cmb_done_comb),
      .cmb_S         (cmb_S),
      .cmb_data      (cmb_data),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_S         (out_S),
      .out_data      (out_data),
      .out_ch        (out_ch),
      .timeout_err   (timeout_err)
   );

   always #5 clk = ~clk;

   // Behavioural combiner: shifts in each word, completes after cmb_lat+1 cycles (zero at once).
   int          cmb_lat  = 2;
   bit          cmb_mute = 1'b0;
   logic [63:0] acc_s, acc_d;
   int          words, delay;
   bit          pending, done_r, donec_r;

   always @(posedge clk) begin
      if (!cmb_rst_n) begin
         acc_s   <= 64'h0;
         acc_d   <= 64'h0;
         words   <= 0;
         delay   <= 0;
         pending <= 1'b0;
         done_r  <= 1'b0;
         donec_r <= 1'b0;
      end else begin
         done_r <= 1'b0;
         if (cmb_en) begin
            acc_d   <= {acc_d[47:0], cmb_b};
            acc_s   <= {acc_s[47:0], ~cmb_b};
            words   <= words + 1;
            pending <= 1'b1;
            delay   <= (cmb_b == 16'h0) ? 0 : cmb_lat;
         end else if (pending && !cmb_mute) begin
            if (delay == 0) begin
               pending <= 1'b0;
               if (words == 1) done_r <= 1'b1;
               else donec_r <= 1'b1;
            end else begin
               delay <= delay - 1;
            end
         end
      end
   end

   assign cmb_done      = done_r;
   assign cmb_done_comb = donec_r;
   assign cmb_S         = acc_s;
   assign cmb_data      = acc_d;

   function automatic logic [63:0] ref_data(input logic [15:0] a, input logic [15:0] b);
      return {32'h0, a, b};
   endfunction

   function automatic logic [63:0] ref_s(input logic [15:0] a, input logic [15:0] b);
      return {32'h0, ~a, ~b};
   endfunction

   // Monitor samples a little after each rising edge.
   bit          gnt_log[$];
   logic [15:0] en_log[$];
   bit          hs_ch[$];
   logic [63:0] hs_data[$], hs_s[$];
   int          rstlo_cnt, to_cnt, ov_cnt;
   bit          ov_prev;

   always begin
      @(posedge clk);
      #2;
      if (gnt0) gnt_log.push_back(1'b0);
      if (gnt1) gnt_log.push_back(1'b1);
      if (cmb_en) en_log.push_back(cmb_b);
      if (rst && !cmb_rst_n) rstlo_cnt++;
      if (timeout_err) to_cnt++;
      if (out_valid) ov_cnt++;
      if (ov_prev && !out_valid && rst) begin
         hs_ch.push_back(out_ch);
         hs_data.push_back(out_data);
         hs_s.push_back(out_S);
      end
      ov_prev = out_valid;
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_logs();
      gnt_log.delete();
      en_log.delete();
      hs_ch.delete();
      hs_data.delete();
      hs_s.delete();
      rstlo_cnt = 0;
      to_cnt    = 0;
      ov_cnt    = 0;
   endtask

   task automatic do_reset();
      rst  = 1'b0;
      req0 = 1'b0;
      req1 = 1'b0;
      tick(2);
      rst = 1'b1;
      tick(1);
      clear_logs();
   endtask

   task automatic grant_wait(input bit ch, output int waited);
      bit found = 1'b0;
      waited = 0;
      for (int i = 0; i < 60 && !found; i++) begin
         @(negedge clk);
         if (ch ? gnt1 : gnt0) begin
            found  = 1'b1;
            waited = i + 1;
         end
      end
      if (ch) req1 = 1'b0;
      else req0 = 1'b0;
      if (!found) check("grant_timeout", 64'd0, 64'd1);
   endtask

   task automatic wait_hs(input int n);
      int i = 0;
      while (hs_ch.size() < n && i < 400) begin
         @(negedge clk);
         i++;
      end
      if (hs_ch.size() < n) check("result_timeout", 64'(hs_ch.size()), 64'(n));
   endtask

   task automatic xfer(input bit ch, input logic [15:0] a, input logic [15:0] b);
      int n0, w;
      n0 = hs_ch.size();
      if (ch) begin
         wa1 = a; wb1 = b; req1 = 1'b1;
      end else begin
         wa0 = a; wb0 = b; req0 = 1'b1;
      end
      out_ready = 1'b1;
      grant_wait(ch, w);
      wait_hs(n0 + 1);
   endtask

   task automatic rr_run(input int n);
      int g0 = gnt_log.size();
      int i  = 0;
      req0 = 1'b1;
      req1 = 1'b1;
      while (gnt_log.size() < g0 + n && i < 400) begin
         @(negedge clk);
         req0 = !gnt0;
         req1 = !gnt1;
         i++;
      end
      req0 = 1'b0;
      req1 = 1'b0;
      if (gnt_log.size() < g0 + n) check("rr_grants", 64'(gnt_log.size()), 64'(g0 + n));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int          w;
      bit          stable;
      logic [63:0] snap_d, snap_s;

      rst = 1'b0; req0 = 1'b0; req1 = 1'b0; out_ready = 1'b0;
      wa0 = 16'h0; wb0 = 16'h0; wa1 = 16'h0; wb1 = 16'h0;

      // Reset values
      tick(2);
      check("rst_gnt0", gnt0, 1'b0);
      check("rst_gnt1", gnt1, 1'b0);
      check("rst_cmb_rst_n", cmb_rst_n, 1'b0);
      check("rst_cmb_en", cmb_en, 1'b0);
      check("rst_cmb_b", cmb_b, 16'h0);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_S", out_S, 64'h0);
      check("rst_out_data", out_data, 64'h0);
      check("rst_out_ch", out_ch, 1'b0);
      check("rst_timeout_err", timeout_err, 1'b0);
      rst = 1'b1;
      tick(1);
      check("rel_cmb_rst_n", cmb_rst_n, 1'b1);
      clear_logs();

      // Single pair on channel 0, then a 20-cycle stall with channel 1 waiting
      wa0 = 16'h0005; wb0 = 16'h0009; req0 = 1'b1;
      grant_wait(1'b0, w);
      check("clr_low_with_gnt", cmb_rst_n, 1'b0);
      w = 0;
      while (!out_valid && w < 100) begin
         @(negedge clk);
         w++;
      end
      check("p1_out_valid", out_valid, 1'b1);
      check("p1_out_ch", out_ch, 1'b0);
      check("p1_out_data", out_data, ref_data(16'h0005, 16'h0009));
      check("p1_out_S", out_S, ref_s(16'h0005, 16'h0009));
      check("p1_en_count", 64'(en_log.size()), 64'd2);
      if (en_log.size() == 2) begin
         check("p1_en_wa", en_log[0], 16'h0005);
         check("p1_en_wb", en_log[1], 16'h0009);
      end
      check("p1_clr_cycles", 64'(rstlo_cnt), 64'd1);
      snap_d = out_data;
      snap_s = out_S;
      stable = 1'b1;
      wa1 = 16'h0123; wb1 = 16'h0456; req1 = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (!out_valid || out_data !== snap_d || out_S !== snap_s || out_ch !== 1'b0)
            stable = 1'b0;
      end
      check("stall_stable", stable, 1'b1);
      check("stall_no_gnt", 64'(gnt_log.size()), 64'd1);
      out_ready = 1'b1;
      tick(1);
      check("stall_released", out_valid, 1'b0);
      grant_wait(1'b1, w);
      check("idle_then_grant", 64'(w), 64'd1);
      wait_hs(2);
      if (hs_ch.size() == 2) begin
         check("p2_ch", hs_ch[1], 1'b1);
         check("p2_data", hs_data[1], ref_data(16'h0123, 16'h0456));
      end

      // Round robin from reset: ties go ch0, ch1, ch0
      do_reset();
      out_ready = 1'b1;
      wa0 = 16'h0A01; wb0 = 16'h0A02; wa1 = 16'h0B01; wb1 = 16'h0B02;
      rr_run(3);
      wait_hs(3);
      if (gnt_log.size() == 3) begin
         check("rr_gnt0", gnt_log[0], 1'b0);
         check("rr_gnt1", gnt_log[1], 1'b1);
         check("rr_gnt2", gnt_log[2], 1'b0);
      end
      if (hs_ch.size() == 3) begin
         check("rr_out_ch1", hs_ch[1], 1'b1);
         check("rr_data1", hs_data[1], ref_data(16'h0B01, 16'h0B02));
         check("rr_data2", hs_data[2], ref_data(16'h0A01, 16'h0A02));
      end

      // Back-to-back pairs with sticky done_comb, plus an all-zero pair
      clear_logs();
      xfer(1'b0, 16'h0011, 16'h0022);
      xfer(1'b0, 16'h0033, 16'h0044);
      xfer(1'b0, 16'h0000, 16'h0000);
      check("b2b_count", 64'(hs_ch.size()), 64'd3);
      if (hs_ch.size() == 3) begin
         check("b2b_data0", hs_data[0], ref_data(16'h0011, 16'h0022));
         check("b2b_data1", hs_data[1], ref_data(16'h0033, 16'h0044));
         check("b2b_s1", hs_s[1], ref_s(16'h0033, 16'h0044));
         check("zero_data", hs_data[2], 64'h0);
      end

      // Timeout in WAIT_A on channel 1
      clear_logs();
      cmb_mute = 1'b1;
      wa1 = 16'h0777; wb1 = 16'h0888; req1 = 1'b1;
      grant_wait(1'b1, w);
      w = 0;
      while (!cmb_en && w < 10) begin
         @(negedge clk);
         w++;
      end
      tick(16);
      check("to_not_yet", timeout_err, 1'b0);
      tick(1);
      check("to_pulse", timeout_err, 1'b1);
      check("to_cmb_rst_n", cmb_rst_n, 1'b0);
      tick(1);
      check("to_pulse_end", timeout_err, 1'b0);
      check("to_cmb_rst_n_end", cmb_rst_n, 1'b1);
      cmb_mute = 1'b0;
      check("to_no_valid", 64'(ov_cnt), 64'd0);
      check("to_count", 64'(to_cnt), 64'd1);

      // Aborted channel 1 stays last, so a tie now goes to channel 0
      wa0 = 16'h0C01; wb0 = 16'h0C02;
      rr_run(1);
      wait_hs(1);
      if (gnt_log.size() == 2) check("after_abort_gnt", gnt_log[1], 1'b0);

      // Completion on the boundary cycle beats the abort; one cycle later it does not
      clear_logs();
      cmb_lat = 14;
      xfer(1'b1, 16'h00AB, 16'h00CD);
      check("edge_no_to", 64'(to_cnt), 64'd0);
      if (hs_ch.size() == 1) check("edge_data", hs_data[0], ref_data(16'h00AB, 16'h00CD));
      cmb_lat = 15;
      wa0 = 16'h00EE; wb0 = 16'h00FF; req0 = 1'b1;
      grant_wait(1'b0, w);
      tick(40);
      check("late_to", 64'(to_cnt), 64'd1);
      check("late_no_result", 64'(hs_ch.size()), 64'd1);

      // Reset during WAIT_B
      clear_logs();
      cmb_lat = 10;
      wa0 = 16'h0101; wb0 = 16'h0202; req0 = 1'b1;
      grant_wait(1'b0, w);
      w = 0;
      while (en_log.size() < 2 && w < 60) begin
         @(negedge clk);
         w++;
      end
      tick(3);
      rst = 1'b0;
      #1;
      check("mid_rst_cmb_rst_n", cmb_rst_n, 1'b0);
      check("mid_rst_cmb_b", cmb_b, 16'h0);
      check("mid_rst_cmb_en", cmb_en, 1'b0);
      check("mid_rst_out_valid", out_valid, 1'b0);
      tick(2);
      rst = 1'b1;
      tick(30);
      check("mid_rst_no_valid", 64'(ov_cnt), 64'd0);
      cmb_lat = 2;
      xfer(1'b1, 16'h0303, 16'h0404);
      if (hs_ch.size() == 1) begin
         check("post_rst_ch", hs_ch[0], 1'b1);
         check("post_rst_data", hs_data[0], ref_data(16'h0303, 16'h0404));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
